// File: rtl/ff256_ct_seq_in_buffer.sv
// Ping-pong 8x8-bit input staging for the sequential FF256 transform; x_k is presented combinationally in state S_k (zero latency).
// Backpressure: in_ready drops while the write bank is still full; a released bank is writable from the following cycle.
`ifndef CT_SEQ_IDLE
`define CT_SEQ_IDLE 5'd0
`define CT_SEQ_S0   5'd1
`define CT_SEQ_S1   5'd2
`define CT_SEQ_S2   5'd3
`define CT_SEQ_S3   5'd4
`define CT_SEQ_S4   5'd5
`define CT_SEQ_S5   5'd6
`define CT_SEQ_S6   5'd7
`define CT_SEQ_S7   5'd8
`define CT_SEQ_S8   5'd9
`define CT_SEQ_S9   5'd10
`define CT_SEQ_DONE 5'd11
`endif

module ff256_ct_seq_in_buffer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] state_i,
    output logic       strt_cmpt_o,
    output logic [7:0] x_o,
    output logic       x_valid_o,
    output logic [1:0] full_o
);
    logic [7:0] bank_q [2][8];
    logic       wr_bank_q, wr_bank_d;
    logic [2:0] wr_idx_q, wr_idx_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] full_q, full_d;
    logic       strt_q, strt_d;
    logic       wr_fire;
    logic       rel_fire;
    logic [2:0] rd_k;

    assign in_ready = !full_q[wr_bank_q];
    assign wr_fire  = in_valid && in_ready;
    assign rel_fire = strt_q && (state_i == `CT_SEQ_DONE);

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        strt_d    = strt_q;
        if (wr_fire) begin
            if (wr_idx_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_idx_d          = 3'd0;
            end else begin
                wr_idx_d = wr_idx_q + 3'd1;
            end
        end
        // The write side never targets rd_bank while it is full, so both updates can coexist.
        if (rel_fire) begin
            strt_d            = 1'b0;
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end else if (!strt_q && full_q[rd_bank_q] && (state_i == `CT_SEQ_IDLE)) begin
            strt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            wr_idx_q  <= 3'd0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            strt_q    <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            strt_q    <= strt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_q[wr_bank_q][wr_idx_q] <= in_data;
        end
    end

    assign rd_k = 3'(state_i - `CT_SEQ_S0);

    always_comb begin
        x_o       = 8'h00;
        x_valid_o = 1'b0;
        if ((state_i >= `CT_SEQ_S0) && (state_i <= `CT_SEQ_S7)) begin
            x_o       = bank_q[rd_bank_q][rd_k];
            x_valid_o = 1'b1;
        end
    end

    assign strt_cmpt_o = strt_q;
    assign full_o      = full_q;
endmodule

// File: tb/tb_ff256_ct_seq_in_buffer.sv
// Randomised/directed bench: a behavioural control FSM drives state_i, a block-count model plus data queue checks the buffer.
module tb_ff256_ct_seq_in_buffer;
    localparam logic [4:0] ST_IDLE = 5'd0;
    localparam logic [4:0] ST_S0   = 5'd1;
    localparam logic [4:0] ST_S4   = 5'd5;
    localparam logic [4:0] ST_S7   = 5'd8;
    localparam logic [4:0] ST_S9   = 5'd10;
    localparam logic [4:0] ST_DONE = 5'd11;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] st;
    logic       strt_cmpt_o;
    logic [7:0] x_o;
    logic       x_valid_o;
    logic [1:0] full_o;

    ff256_ct_seq_in_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_i    (st),
        .strt_cmpt_o(strt_cmpt_o),
        .x_o        (x_o),
        .x_valid_o  (x_valid_o),
        .full_o     (full_o)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         tmo_cnt = 0;
    bit         done_req = 1'b0;
    bit         done_seen = 1'b0;
    logic [7:0] exp_q [$];
    int         m_wcnt, m_cmp, m_rel, pend0, done_cnt;
    bit         m_req;
    logic       vexp, strt_s;
    logic [7:0] ex;
    logic [1:0] ef;
    logic [4:0] prev_st;
    logic [4:0] nx;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Behavioural control: IDLE waits for start, S0..S9 step, DONE holds while start is high.
    always @(negedge clk) strt_s <= strt_cmpt_o;

    initial begin
        st = ST_IDLE;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                st = ST_IDLE;
            end else begin
                if (st == ST_IDLE)      nx = strt_s ? ST_S0 : ST_IDLE;
                else if (st == ST_DONE) nx = strt_s ? ST_DONE : ST_IDLE;
                else if (st == ST_S9)   nx = ST_DONE;
                else                    nx = st + 5'd1;
                #1;
                st = nx;
            end
        end
    end

    // Monitor / scoreboard: blocks completed vs released decides readiness, full flags and start.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            #1;
            exp_q.delete();
            m_wcnt = 0; m_cmp = 0; m_rel = 0; m_req = 1'b0;
            done_cnt = 0; prev_st = ST_IDLE;
            chk("rst_strt", strt_cmpt_o, 0);
            chk("rst_full", full_o, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_x_valid", x_valid_o, 0);
            chk("rst_x", x_o, 0);
        end else begin
            vexp = (st >= ST_S0) && (st <= ST_S7);
            chk("x_valid", x_valid_o, vexp);
            if (vexp) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL x_data: got %0h with nothing expected at %0t", x_o, $time);
                end else begin
                    ex = exp_q.pop_front();
                    chk("x_data", x_o, ex);
                end
            end else begin
                chk("x_idle_zero", x_o, 0);
            end
            pend0 = m_cmp - m_rel;
            ef = 2'b00;
            for (int b = m_rel; b < m_cmp; b++) ef[b % 2] = 1'b1;
            chk("in_ready", in_ready, pend0 < 2);
            chk("strt", strt_cmpt_o, m_req);
            chk("full", full_o, ef);
            if (st == ST_DONE) begin
                done_cnt++;
            end else if (prev_st == ST_DONE) begin
                chk("done_cycles", done_cnt, 2);
                chk("strt_after_done", strt_cmpt_o, 0);
                done_cnt = 0;
            end
            prev_st = st;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                m_wcnt++;
                if (m_wcnt == 8) begin
                    m_wcnt = 0;
                    m_cmp++;
                end
            end
            if (m_req && st == ST_DONE) begin
                m_req = 1'b0;
                m_rel++;
            end else if (!m_req && pend0 > 0 && st == ST_IDLE) begin
                m_req = 1'b1;
            end
            if (done_req && !done_seen) begin
                chk("timeouts", tmo_cnt, 0);
                done_seen = 1'b1;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the element.
    task automatic send(input logic [7:0] d, input bit gap);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tmo_cnt++;
            $display("FAIL send_stall: element %0h never accepted", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && st == ST_IDLE && !strt_cmpt_o && full_o == 2'b00) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            tmo_cnt++;
            $display("FAIL wait_idle: pipeline not drained after %0d cycles", budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) send(8'(8'h01 + i), 1'b0);
        wait_idle(300);
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0);
        wait_idle(400);
        for (int i = 0; i < 24; i++) send(8'(8'h20 + i), 1'b0);
        wait_idle(600);
        for (int i = 0; i < 8; i++) send(8'(8'h40 + i), 1'b1);
        wait_idle(300);

        for (int i = 0; i < 5; i++) send(8'(8'h50 + i), 1'b0);
        @(negedge clk);
        pulse_reset();
        for (int i = 0; i < 8; i++) send(8'(8'h60 + i), 1'b0);
        n = 0;
        @(negedge clk);
        while (st != ST_S4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (st != ST_S4) begin
            tmo_cnt++;
            $display("FAIL wait_s4: control never reached S4");
        end
        pulse_reset();
        for (int i = 0; i < 8; i++) send(8'(8'h70 + i), 1'b0);
        wait_idle(300);

        for (int i = 0; i < 48; i++) send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        wait_idle(2000);

        done_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
